piso_frame_tx: RTL
==================

Name: piso_frame_tx

Overview:
Parallel-in/serial-out frame transmitter. It drives the single-bit serial line consumed by the serial-in shift-register receiver (DATAIN -> Q[8:0]).
- A WIDTH-bit word is accepted on a ready/load handshake.
- The word is shifted out one bit per CLK cycle, MSB first by default, with a frame-valid qualifier.
- A one-cycle DONE pulse marks the end of the frame.

Parameters:
- WIDTH, 9: word/frame length in bits; legal range 2..16.
- LSB_FIRST, 0: 0 sends bit WIDTH-1 first; 1 sends bit 0 first.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- LOAD  input  1  request to transmit DIN; honoured only when READY=1.
- DIN  input  WIDTH  parallel word, sampled on the accepting edge only.
- READY  output  1  block idle and able to accept LOAD.
- DATAOUT  output  1  serial data; connects to the receiver's DATAIN.
- FRAME  output  1  high while DATAOUT carries a valid frame bit.
- DONE  output  1  one-cycle pulse after the final frame bit.

Behaviour:
- Reset (RST high at a posedge):
  - State goes to IDLE; shift register and bit counter cleared.
  - DATAOUT=0, FRAME=0, DONE=0, READY=1.
  - RST overrides LOAD and any in-progress frame.
- States: IDLE, SHIFT, PAR (only with the optional feature).
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - READY=1, FRAME=0, DATAOUT=0.
  - LOAD=1 at edge N captures DIN, clears the bit counter and moves to SHIFT.
- SHIFT:
  - From edge N onward, FRAME=1 and DATAOUT=first bit.
  - Bit k (k=0..WIDTH-1) is valid after edge N+k.
  - Counter counts 0..WIDTH-1 and does not wrap within a frame.
  - At edge N+WIDTH: go to IDLE (or PAR), with FRAME=0, DATAOUT=0, DONE=1 for exactly one cycle, READY=1.
- Timing summary:
  - Frame occupies exactly WIDTH cycles.
  - Minimum frame-to-frame spacing is WIDTH+1 cycles; the IDLE/DONE cycle may itself accept the next LOAD.
- Handshake rules:
  - LOAD while READY=0 is ignored: no capture, no queuing, no output change.
  - DIN changes after capture have no effect on the frame in flight.
- Reset mid-frame:
  - Frame aborts.
  - At that edge DATAOUT=0, FRAME=0, and DONE stays 0 (no completion is signalled for an aborted frame).
- LOAD and RST together: RST wins; the word is discarded.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit, one extra PAR cycle drives DATAOUT = XOR of the captured word (even parity) with FRAME=1.
  - DONE and READY follow one cycle later, so the frame is WIDTH+1 cycles.
- Undefined: PAR state, parity logic and the extra cycle do not exist; timing is as above.

Decomposition:
- Shared package serial_link_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, PAR} tx_state_t.
  - localparam FRAME_W = 9 (shared with the receiver).
  - function even_parity(word).
- Sub-modules: none. Counter, shift register and FSM are one block; splitting them adds no reuse.

Test Plan:
- Reset: hold RST 3 cycles with LOAD=1, DIN=9'h1FF -> READY=1, DATAOUT=0, FRAME=0, DONE=0 throughout; nothing transmitted.
- Single frame: LOAD with DIN=9'h1A5, MSB first -> DATAOUT=1,1,0,1,0,0,1,0,1 on 9 consecutive cycles with FRAME=1; DONE=1 on the 10th cycle only. Loopback into the receiver gives Q=9'h1A5.
- Leading-ones sweep: send 9'h100, 9'h180, ..., 9'h1FF -> DATAOUT high for exactly 1..9 leading cycles respectively; receiver loopback reports matching leading-high counts.
- Busy rejection: second LOAD with DIN=9'h000 at cycle 3 of a 9'h1FF frame -> ignored; all 9 bits =1; only one DONE pulse.
- Back-to-back and mid-frame reset: LOAD held high continuously -> frames start every 10 cycles. Separately, RST at bit 4 -> DATAOUT=0 and FRAME=0 from that edge, DONE never pulses, READY=1 the next cycle.
- PISO_PARITY_EN: DIN=9'h1A5 (five ones) -> 10th frame bit DATAOUT=1 with FRAME=1; DONE on the 11th cycle.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the serial link (transmitter and receiver).
// The optional parity cycle is enabled with the PISO_PARITY_EN macro.
package serial_link_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, PAR} tx_state_t;

   localparam int FRAME_W = 9;

   // Words up to 16 bits are zero-extended by the caller; zeros do not change parity.
   function automatic logic even_parity(input logic [15:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/piso_frame_tx.sv
// Parallel-in/serial-out frame transmitter with ready/load handshake and DONE pulse.
// Define PISO_PARITY_EN to append one even-parity bit after the data bits.
module piso_frame_tx
   import serial_link_pkg::*;
#(
   parameter int WIDTH     = 9,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] DIN,
   output logic             READY,
   output logic             DATAOUT,
   output logic             FRAME,
   output logic             DONE
);

   localparam int CW = $clog2(WIDTH);

   tx_state_t        state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
`ifdef PISO_PARITY_EN
   logic             par;
`endif

   logic             first_bit;
   logic [WIDTH-1:0] din_rest;
   logic             next_bit;
   logic [WIDTH-1:0] sh_rest;
   logic             last;

   // The first bit goes straight to DATAOUT on the accepting edge, so the
   // shift register only holds the bits still to be sent.
   always_comb begin
      first_bit = DIN[WIDTH-1];
      din_rest  = DIN << 1;
      next_bit  = shreg[WIDTH-1];
      sh_rest   = shreg << 1;
      if (LSB_FIRST) begin
         first_bit = DIN[0];
         din_rest  = DIN >> 1;
         next_bit  = shreg[0];
         sh_rest   = shreg >> 1;
      end
      last = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         shreg   <= '0;
         cnt     <= '0;
         DATAOUT <= 1'b0;
         FRAME   <= 1'b0;
         DONE    <= 1'b0;
         READY   <= 1'b1;
`ifdef PISO_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               DONE <= 1'b0;
               if (LOAD && READY) begin
                  shreg   <= din_rest;
                  cnt     <= '0;
                  DATAOUT <= first_bit;
                  FRAME   <= 1'b1;
                  READY   <= 1'b0;
                  state   <= SHIFT;
`ifdef PISO_PARITY_EN
                  par     <= even_parity(16'(DIN));
`endif
               end
            end

            SHIFT: begin
               if (last) begin
`ifdef PISO_PARITY_EN
                  DATAOUT <= par;
                  state   <= PAR;
`else
                  DATAOUT <= 1'b0;
                  FRAME   <= 1'b0;
                  DONE    <= 1'b1;
                  READY   <= 1'b1;
                  state   <= IDLE;
`endif
               end else begin
                  cnt     <= cnt + CW'(1);
                  DATAOUT <= next_bit;
                  shreg   <= sh_rest;
               end
            end

`ifdef PISO_PARITY_EN
            PAR: begin
               DATAOUT <= 1'b0;
               FRAME   <= 1'b0;
               DONE    <= 1'b1;
               READY   <= 1'b1;
               state   <= IDLE;
            end
`endif

            default: begin
               DATAOUT <= 1'b0;
               FRAME   <= 1'b0;
               DONE    <= 1'b0;
               READY   <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
